instr_fetch_ctrl: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences the word-addressed code memory (256 x 32, combinational read) for the pipeline.
- Presents one fetched instruction per cycle to the decode stage through a valid/ready output register.
- Handles redirects (jump/branch) and decode back-pressure.
- Arbitrates the code-memory address port between normal fetch and a program-load writer; load has priority.

---
 rtl/instr_fetch_ctrl.sv | 92 +++++++++
 tb/tb_instr_fetch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, feeds decode through a
// valid/ready register and yields the code-memory port to a program loader.
module instr_fetch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy_load
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] LOAD  = 1'b1;

  localparam logic [ADDR_W-1:0] PC_RST =
    ADDR_W'(RESET_PC);

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              in_load;

  assign in_load = (state == LOAD);
  assign accept  = !if_valid || id_ready;

  // Address mux sees only state, pc and load_addr.
  always_comb begin
    imem_addr = 32'd0;
    if (in_load)
      imem_addr[ADDR_W-1:0] = load_addr;
    else
      imem_addr[ADDR_W-1:0] = pc;
  end

  assign imem_we    = in_load && load_req;
  assign imem_wdata = load_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= PC_RST;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      busy_load <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (load_req) begin
            state     <= LOAD;
            if_valid  <= 1'b0;
            busy_load <= 1'b1;
          end else if (redirect_valid) begin
            if_valid <= 1'b0;
            pc       <= redirect_pc;
          end else if (accept) begin
            if_valid <= 1'b1;
            if_instr <= imem_instr;
            if_pc    <= pc;
            pc       <= pc + 1'b1;
          end
        end
        LOAD: begin
          if_valid <= 1'b0;
          if (!load_req) begin
            state     <= FETCH;
            pc        <= PC_RST;
            busy_load <= 1'b0;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: vector table for fetch, stall,
// redirect and wrap; hand sequences for program load and reset in LOAD.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic        load_req;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        busy_load;

  logic [31:0] mem [256];
  int total = 0;
  int bad   = 0;
  int we_cnt;

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .imem_we(imem_we), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc),
    .load_req(load_req), .load_addr(load_addr),
    .load_data(load_data), .busy_load(busy_load)
  );

  assign imem_instr = mem[imem_addr[7:0]];

  always @(posedge clk)
    if (imem_we) mem[imem_addr[7:0]] <= imem_wdata;

  function automatic logic [31:0] word_at(input int a);
    return 32'h04221800 + 32'h00010001 * a;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rdy;
    logic       rv;
    logic [7:0] rpc;
    logic       ev;
    logic [7:0] epc;
    logic [7:0] eaddr;
  } vec_t;

  vec_t vt [16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word_at(i);
    rst_n = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    load_req = 1'b0; load_addr = '0; load_data = '0;

    // rdy, rv, rpc, exp valid, exp if_pc, exp imem_addr
    vt[0]  = '{1, 0, 8'h00, 1, 8'h00, 8'h01};
    vt[1]  = '{1, 0, 8'h00, 1, 8'h01, 8'h02};
    vt[2]  = '{1, 0, 8'h00, 1, 8'h02, 8'h03};
    vt[3]  = '{0, 0, 8'h00, 1, 8'h02, 8'h03};
    vt[4]  = '{0, 0, 8'h00, 1, 8'h02, 8'h03};
    vt[5]  = '{0, 0, 8'h00, 1, 8'h02, 8'h03};
    vt[6]  = '{1, 0, 8'h00, 1, 8'h03, 8'h04};
    vt[7]  = '{1, 0, 8'h00, 1, 8'h04, 8'h05};
    vt[8]  = '{0, 1, 8'h10, 0, 8'h00, 8'h10};
    vt[9]  = '{0, 0, 8'h00, 1, 8'h10, 8'h11};
    vt[10] = '{1, 0, 8'h00, 1, 8'h11, 8'h12};
    vt[11] = '{1, 1, 8'hFE, 0, 8'h00, 8'hFE};
    vt[12] = '{1, 0, 8'h00, 1, 8'hFE, 8'hFF};
    vt[13] = '{1, 0, 8'h00, 1, 8'hFF, 8'h00};
    vt[14] = '{1, 0, 8'h00, 1, 8'h00, 8'h01};
    vt[15] = '{1, 0, 8'h00, 1, 8'h01, 8'h02};

    tick(); tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", {24'd0, if_pc}, 32'd0);
    chk("rst_busy", {31'd0, busy_load}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id_ready       = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      tick();
      redirect_valid = 1'b0;
      chk($sformatf("v%0d_valid", i),
          {31'd0, if_valid}, {31'd0, vt[i].ev});
      chk($sformatf("v%0d_addr", i),
          imem_addr, {24'd0, vt[i].eaddr});
      if (vt[i].ev) begin
        chk($sformatf("v%0d_pc", i),
            {24'd0, if_pc}, {24'd0, vt[i].epc});
        chk($sformatf("v%0d_instr", i),
            if_instr, word_at(int'(vt[i].epc)));
      end
    end

    // Program load: entry cycle, three writes, exit.
    id_ready  = 1'b1;
    we_cnt    = 0;
    load_req  = 1'b1;
    load_addr = 8'd0;
    load_data = 32'hAAAA0001;
    #1;
    chk("ld_entry_we", {31'd0, imem_we}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      load_addr = 8'(k);
      load_data = 32'hAAAA0001 + k;
      #1;
      if (imem_we) we_cnt++;
      chk($sformatf("ld%0d_busy", k),
          {31'd0, busy_load}, 32'd1);
      chk($sformatf("ld%0d_valid", k),
          {31'd0, if_valid}, 32'd0);
      chk($sformatf("ld%0d_addr", k),
          imem_addr, k);
    end
    tick();
    load_req = 1'b0;
    #1;
    if (imem_we) we_cnt++;
    chk("ld_last_busy", {31'd0, busy_load}, 32'd1);
    chk("ld_last_valid", {31'd0, if_valid}, 32'd0);
    chk("ld_we_count", we_cnt, 32'd3);
    tick();
    chk("ld_exit_busy", {31'd0, busy_load}, 32'd0);
    chk("ld_exit_valid", {31'd0, if_valid}, 32'd0);
    chk("ld_exit_addr", imem_addr, 32'd0);
    tick();
    chk("ld_f0_valid", {31'd0, if_valid}, 32'd1);
    chk("ld_f0_pc", {24'd0, if_pc}, 32'd0);
    chk("ld_f0_instr", if_instr, 32'hAAAA0001);
    tick();
    chk("ld_f1_pc", {24'd0, if_pc}, 32'd1);
    chk("ld_f1_instr", if_instr, 32'hAAAA0002);
    tick();
    chk("ld_f2_instr", if_instr, 32'hAAAA0003);

    // Reset while in LOAD with load_req still high.
    load_req  = 1'b1;
    load_addr = 8'd5;
    load_data = 32'h5555_0000;
    tick();
    chk("rl_busy", {31'd0, busy_load}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rl_busy0", {31'd0, busy_load}, 32'd0);
    chk("rl_we0", {31'd0, imem_we}, 32'd0);
    chk("rl_valid0", {31'd0, if_valid}, 32'd0);
    chk("rl_addr0", imem_addr, 32'd0);
    rst_n    = 1'b1;
    load_req = 1'b0;
    tick();
    chk("rl_f0_valid", {31'd0, if_valid}, 32'd1);
    chk("rl_f0_pc", {24'd0, if_pc}, 32'd0);
    chk("rl_f0_instr", if_instr, 32'hAAAA0001);
    tick();
    chk("rl_f1_pc", {24'd0, if_pc}, 32'd1);
    chk("rl_f1_busy", {31'd0, busy_load}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
